// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and digit check for the BCD word-to-binary converter.
package bcd_pkg;

  localparam int unsigned NUM_DIGITS = 10;
  localparam int unsigned BIN_W      = 34;
  localparam int unsigned MAX_CONV   = 300;
  localparam int unsigned CNT_W      = 9;
  localparam int unsigned WORD_W     = 4 * NUM_DIGITS;
  localparam int unsigned DCNT_W     = $clog2(NUM_DIGITS);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  function automatic logic digit_valid(input logic [3:0] nibble);
    return nibble <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_mul10_add.sv
// One Horner step: acc*10 + digit, with invalid digits contributing zero.
module bcd_mul10_add
  import bcd_pkg::*;
(
  input  logic [BIN_W-1:0] i_acc,
  input  logic [3:0]       i_digit,
  output logic [BIN_W-1:0] o_acc,
  output logic             o_invalid
);

  logic [BIN_W-1:0] w_digit;

  always_comb begin
    o_invalid = ~digit_valid(i_digit);
    w_digit   = o_invalid ? '0 : {{(BIN_W-4){1'b0}}, i_digit};
    o_acc     = (i_acc << 3) + (i_acc << 1) + w_digit;
  end

endmodule

// File: rtl/bcd_word_to_bin.sv
// Iterative 10-digit packed BCD to binary converter, MSD first, valid/ready on both sides,
// with a per-reset limit on the number of delivered results.
module bcd_word_to_bin
  import bcd_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] bcd_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BIN_W-1:0]  bin_out,
  output logic              digit_err,
  output logic [CNT_W-1:0]  conv_cnt,
  output logic              frame_done
);

  state_t              r_state;
  state_t              w_next;
  logic [WORD_W-1:0]   r_shreg;
  logic [BIN_W-1:0]    r_acc;
  logic [DCNT_W-1:0]   r_dcnt;
  logic                r_err;
  logic [BIN_W-1:0]    r_bin;
  logic                r_derr;
  logic [CNT_W-1:0]    r_cnt;
  logic [BIN_W-1:0]    w_mac;
  logic                w_inv;
  logic                w_last;
  logic                w_frame_done;
  logic                w_accept;

  bcd_mul10_add u_mac (
    .i_acc     (r_acc),
    .i_digit   (r_shreg[WORD_W-1 -: 4]),
    .o_acc     (w_mac),
    .o_invalid (w_inv)
  );

  assign w_last       = (r_dcnt == DCNT_W'(NUM_DIGITS - 1));
  assign w_frame_done = (r_cnt == CNT_W'(MAX_CONV));
  assign w_accept     = in_valid & in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = ~w_frame_done;
        if (in_valid && !w_frame_done) w_next = CONV;
      end
      CONV: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // bin_out/digit_err are loaded on the final digit so they stay put outside DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shreg <= '0;
      r_acc   <= '0;
      r_dcnt  <= '0;
      r_err   <= 1'b0;
      r_bin   <= '0;
      r_derr  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shreg <= bcd_in;
            r_acc   <= '0;
            r_err   <= 1'b0;
            r_dcnt  <= '0;
          end
        end
        CONV: begin
          r_acc   <= w_mac;
          r_err   <= r_err | w_inv;
          r_shreg <= {r_shreg[WORD_W-5:0], 4'h0};
          r_dcnt  <= r_dcnt + 1'b1;
          if (w_last) begin
            r_bin  <= w_mac;
            r_derr <= r_err | w_inv;
          end
        end
        DONE: begin
          if (out_ready && !w_frame_done) r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bin_out    = r_bin;
  assign digit_err  = r_derr;
  assign conv_cnt   = r_cnt;
  assign frame_done = w_frame_done;

endmodule

// File: tb/tb_bcd_word_to_bin.sv
// Directed self-checking bench for bcd_word_to_bin.
module tb_bcd_word_to_bin;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [39:0] bcd_in;
  logic        out_valid;
  logic        out_ready;
  logic [33:0] bin_out;
  logic        digit_err;
  logic [8:0]  conv_cnt;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bcd_word_to_bin dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .bcd_in     (bcd_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .bin_out    (bin_out),
    .digit_err  (digit_err),
    .conv_cnt   (conv_cnt),
    .frame_done (frame_done)
  );

  // Stimulus helpers only; every comparison lives in the test tasks.
  task automatic accept_word(input logic [39:0] w, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (in_ready === 1'b1) begin
      in_valid = 1'b1;
      bcd_in   = w;
      @(posedge clk); #1;
      in_valid = 1'b0;
      ok       = 1'b1;
    end
  endtask

  task automatic wait_result(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; bcd_in = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, bin_out, digit_err, conv_cnt, frame_done} !== '0)
      begin n_fail++; $display("FAIL reset_outputs: got v=%0b bin=%0d err=%0b cnt=%0d fd=%0b, expected all 0",
        out_valid, bin_out, digit_err, conv_cnt, frame_done); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_zero();
    bit ok; int cyc;
    accept_word(40'h0000000000, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL zero_accept: got timeout expected accept"); end
    wait_result(cyc);
    n_checks++;
    if (cyc !== 10) begin n_fail++; $display("FAIL zero_latency: got %0d expected 10", cyc); end
    n_checks++;
    if (bin_out !== 34'd0 || digit_err !== 1'b0)
      begin n_fail++; $display("FAIL zero_value: got bin=%0d err=%0b expected bin=0 err=0", bin_out, digit_err); end
    consume();
    n_checks++;
    if (conv_cnt !== 9'd1) begin n_fail++; $display("FAIL zero_cnt: got %0d expected 1", conv_cnt); end
  endtask

  task automatic test_values();
    logic [39:0] vin  [5];
    logic [33:0] vexp [5];
    logic        verr [5];
    bit ok; int cyc;
    vin[0] = 40'h9999999999; vexp[0] = 34'h2540BE3FF; verr[0] = 1'b0;
    vin[1] = 40'h0000000123; vexp[1] = 34'd123;        verr[1] = 1'b0;
    vin[2] = 40'h00000001A5; vexp[2] = 34'd105;        verr[2] = 1'b1;
    vin[3] = 40'hFFFFFFFFFF; vexp[3] = 34'd0;          verr[3] = 1'b1;
    vin[4] = 40'h1234567890; vexp[4] = 34'd1234567890; verr[4] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      accept_word(vin[i], ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL values_accept[%0d]: got timeout expected accept", i); end
      wait_result(cyc);
      n_checks++;
      if (cyc !== 10) begin n_fail++; $display("FAIL values_latency[%0d]: got %0d expected 10", i, cyc); end
      n_checks++;
      if (bin_out !== vexp[i]) begin n_fail++; $display("FAIL values_bin[%0d]: got %0d expected %0d", i, bin_out, vexp[i]); end
      n_checks++;
      if (digit_err !== verr[i]) begin n_fail++; $display("FAIL values_err[%0d]: got %0b expected %0b", i, digit_err, verr[i]); end
      consume();
    end
    n_checks++;
    if (conv_cnt !== 9'd6) begin n_fail++; $display("FAIL values_cnt: got %0d expected 6", conv_cnt); end
  endtask

  task automatic test_backpressure();
    bit ok; int cyc;
    accept_word(40'h0000000055, ok);
    wait_result(cyc);
    n_checks++;
    if (!ok || cyc !== 10 || bin_out !== 34'd55)
      begin n_fail++; $display("FAIL bp_first: got ok=%0b lat=%0d bin=%0d expected ok=1 lat=10 bin=55", ok, cyc, bin_out); end
    in_valid = 1'b1;
    bcd_in   = 40'h0000000066;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || bin_out !== 34'd55 || digit_err !== 1'b0 || in_ready !== 1'b0)
        begin n_fail++; $display("FAIL bp_hold[%0d]: got v=%0b bin=%0d err=%0b rdy=%0b expected v=1 bin=55 err=0 rdy=0",
          i, out_valid, bin_out, digit_err, in_ready); end
    end
    consume();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin n_fail++; $display("FAIL bp_no_same_cycle_accept: got rdy=%0b v=%0b expected rdy=1 v=0", in_ready, out_valid); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_second_accept: got rdy=%0b expected 0", in_ready); end
    wait_result(cyc);
    n_checks++;
    if (cyc !== 10 || bin_out !== 34'd66)
      begin n_fail++; $display("FAIL bp_second: got lat=%0d bin=%0d expected lat=10 bin=66", cyc, bin_out); end
    consume();
    n_checks++;
    if (conv_cnt !== 9'd8) begin n_fail++; $display("FAIL bp_cnt: got %0d expected 8", conv_cnt); end
  endtask

  task automatic test_reset_mid();
    bit ok; int cyc;
    accept_word(40'h1234567890, ok);
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, bin_out, digit_err, conv_cnt, frame_done} !== '0 || in_ready !== 1'b1)
      begin n_fail++; $display("FAIL midreset_outputs: got v=%0b bin=%0d err=%0b cnt=%0d fd=%0b rdy=%0b expected 0s rdy=1",
        out_valid, bin_out, digit_err, conv_cnt, frame_done, in_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
    accept_word(40'h0000000042, ok);
    wait_result(cyc);
    n_checks++;
    if (!ok || cyc !== 10 || bin_out !== 34'd42 || digit_err !== 1'b0)
      begin n_fail++; $display("FAIL midreset_next: got ok=%0b lat=%0d bin=%0d err=%0b expected ok=1 lat=10 bin=42 err=0",
        ok, cyc, bin_out, digit_err); end
    consume();
    n_checks++;
    if (conv_cnt !== 9'd1) begin n_fail++; $display("FAIL midreset_cnt: got %0d expected 1", conv_cnt); end
  endtask

  task automatic test_back_to_back_frame();
    bit ok; int cyc; bit seen;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 300; i++) begin
      accept_word(40'h0000000007, ok);
      wait_result(cyc);
      n_checks++;
      if (!ok || cyc !== 10 || bin_out !== 34'd7 || digit_err !== 1'b0)
        begin n_fail++; $display("FAIL frame_word[%0d]: got ok=%0b lat=%0d bin=%0d err=%0b expected ok=1 lat=10 bin=7 err=0",
          i, ok, cyc, bin_out, digit_err); end
      consume();
    end
    n_checks++;
    if (conv_cnt !== 9'd300 || frame_done !== 1'b1 || in_ready !== 1'b0)
      begin n_fail++; $display("FAIL frame_end: got cnt=%0d fd=%0b rdy=%0b expected cnt=300 fd=1 rdy=0",
        conv_cnt, frame_done, in_ready); end
    in_valid = 1'b1;
    bcd_in   = 40'h0000000008;
    seen     = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) seen = 1'b1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (seen || conv_cnt !== 9'd300 || frame_done !== 1'b1)
      begin n_fail++; $display("FAIL frame_locked: got activity=%0b cnt=%0d fd=%0b expected activity=0 cnt=300 fd=1",
        seen, conv_cnt, frame_done); end
    reset = 1'b1;
    #1;
    n_checks++;
    if (frame_done !== 1'b0 || conv_cnt !== 9'd0 || in_ready !== 1'b1)
      begin n_fail++; $display("FAIL frame_reset: got fd=%0b cnt=%0d rdy=%0b expected fd=0 cnt=0 rdy=1",
        frame_done, conv_cnt, in_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; bcd_in = '0;
    test_reset();
    test_zero();
    test_values();
    test_backpressure();
    test_reset_mid();
    test_back_to_back_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
